id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage directly downstream of instruction fetch. Captures each fetched word
//  (one-cycle hit pulse), reads the register file, decodes a MIPS-I subset, and resolves
//  J/JAL/JR/BEQ/BNE. Returns pc_we plus the redirect to fetch and issues one decoded bundle per
//  instruction to EX over a valid/ready handshake.
// PARAMETERS
//  DATA_W     32  datapath/register width
//  REG_AW     5   register address width (2**REG_AW registers, r0 reads 0)
//  WB_BYPASS  1   1: a same-cycle WB write is forwarded to the rs/rt read
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low reset
//  instruction   in   32      fetched word, valid when hit=1
//  pc_next       in   32      PC+4 of that word
//  hit           in   1       one-cycle pulse: new instruction/pc_next present
//  pc_we         out  1       one-cycle pulse: fetch may advance
//  is_jump       out  1       with pc_we: take jump_addr
//  jump_addr     out  32      J/JAL/JR target
//  is_branch     out  1       with pc_we: branch taken, take branch_addr
//  branch_addr   out  32      BEQ/BNE target
//  flush         in   1       discard held instruction, suppress issue
//  ex_ready      in   1       EX accepts bundle this cycle
//  ex_load_rd    in   REG_AW  dest of load currently in EX
//  ex_load_vld   in   1       EX holds a load writing ex_load_rd
//  wb_we         in   1       register write enable
//  wb_addr       in   REG_AW  write address
//  wb_data       in   DATA_W  write data
//  id_valid      out  1       bundle below valid
//  rs_data       out  DATA_W  / rt_data out DATA_W: operand values
//  imm           out  DATA_W  extended immediate (sign: addi/lw/sw; zero: andi/ori; lui: imm<<16)
//  rd_addr       out  REG_AW  destination (rd for R-type, rt for I-type, 31 for JAL)
//  alu_op        out  4       ALU operation (encodings in package)
//  alu_src_imm   out  1       / mem_read out 1 / mem_write out 1 / reg_write out 1: control
//  pc_plus4      out  32      link value / PC+4 of issued instruction
//  illegal       out  1       unsupported opcode/funct; bundle issued as NOP (reg_write=0, mem_*=0)
// BEHAVIOUR
//  - Reset: all outputs 0, state EMPTY, buffer 0; register file contents are NOT reset.
//  - FSM EMPTY -> HELD on hit (latch instruction, pc_next). HELD -> EMPTY on issue.
//    HELD -> EMPTY on flush (no issue, no pc_we). flush in EMPTY drops a coincident hit.
//  - Issue in HELD when ex_ready=1 and no hazard: bundle registered, id_valid=1 for exactly
//    one cycle, and pc_we/is_jump/is_branch/addresses pulsed in the same cycle. Decode-to-issue
//    latency: 1 cycle after hit when unstalled.
//  - Hazard: ex_load_vld && ex_load_rd!=0 && ex_load_rd in {rs,rt actually used} -> stay HELD.
//  - While stalled (!ex_ready or hazard): id_valid=0, pc_we=0, held word unchanged; a hit
//    in HELD is a protocol error (fetch cannot advance without pc_we); assertion only.
//  - Operands re-read every HELD cycle, so WB writes during a stall are picked up.
//  - jump_addr: J/JAL {pc_next[31:28], instr[25:0], 2'b00}; JR rs_data. is_jump=1 for all three.
//  - branch_addr = pc_next + (sext(instr[15:0])<<2), 32-bit wrap-around, no overflow flag.
//    is_branch=1 only if BEQ equal / BNE unequal. No delay slot; fetch never runs wrong path.
//  - Write to r0 ignored; reads of r0 return 0 even with WB_BYPASS.
//  - reset asserted mid-stall: state EMPTY immediately, no pulse on pc_we or id_valid.
//  - Decoded set: R add/sub/and/or/slt/sll/jr; I addi/andi/ori/lui/lw/sw/beq/bne; J j/jal.
// STRUCTURE
//  - Shared package ace_pkg: opcode/funct localparams, ALU_* alu_op encodings, state encodings.
//  - Sub-module regfile: 2 async read, 1 sync write, r0 zero, optional WB bypass.
//  - id_stage: FSM, buffer, decoder (combinational), branch/jump unit, output register.
// TESTING
//  1 reset low, hit with 0x20090005 (addi r9,r0,5) -> next cycle id_valid=1, imm=5, rd=9, pc_we=1.
//  2 r1=r2=7 via WB; BEQ r1,r2,+3 at pc_next=0x104 -> is_branch=1, branch_addr=0x110; BNE -> 0.
//  3 J 0x0000040 with pc_next=0xA0000004 -> is_jump=1, jump_addr=0xA0000100; JAL -> rd=31.
//  4 ex_load_vld=1, ex_load_rd=3, held ADD r4,r3,r5 -> 0 id_valid/pc_we until load_vld drops.
//  5 ex_ready=0 three cycles then 1 -> exactly one issue; flush in HELD -> no issue, EMPTY.
//  6 WB write r8=0xDEAD same cycle as decode of OR r1,r8,r0 -> rs_data=0xDEAD; r0 write -> reads 0.

Source files
------------

// File: rtl/ace_pkg.sv
// ---------------------------------------------------------------------------
// ace_pkg : opcode/funct codes, ALU encodings, decode FSM states and decoder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ace_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_LUI  = 4'd6;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } id_state_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        uses_rs;
        logic        uses_rt;
        logic        jump;
        logic        jump_reg;
        logic        beq;
        logic        bne;
        logic        illegal;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                d.rd        = instr[15:11];
                d.uses_rs   = 1'b1;
                d.uses_rt   = 1'b1;
                d.reg_write = 1'b1;
                case (instr[5:0])
                    FN_ADD: d.alu_op = ALU_ADD;
                    FN_SUB: d.alu_op = ALU_SUB;
                    FN_AND: d.alu_op = ALU_AND;
                    FN_OR:  d.alu_op = ALU_OR;
                    FN_SLT: d.alu_op = ALU_SLT;
                    FN_SLL: begin
                        d.alu_op  = ALU_SLL;
                        d.uses_rs = 1'b0;
                        d.imm     = {27'd0, instr[10:6]};
                    end
                    FN_JR: begin
                        d.rd        = 5'd0;
                        d.uses_rt   = 1'b0;
                        d.reg_write = 1'b0;
                        d.jump      = 1'b1;
                        d.jump_reg  = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_J:   d.jump = 1'b1;
            OP_JAL: begin
                d.jump      = 1'b1;
                d.rd        = 5'd31;
                d.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.alu_op  = ALU_SUB;
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
                d.rd      = instr[20:16];
                d.beq     = (instr[31:26] == OP_BEQ);
                d.bne     = (instr[31:26] == OP_BNE);
                d.imm     = {{16{instr[15]}}, instr[15:0]};
            end
            OP_ADDI, OP_LW, OP_SW: begin
                d.alu_op      = ALU_ADD;
                d.alu_src_imm = 1'b1;
                d.uses_rs     = 1'b1;
                d.uses_rt     = (instr[31:26] == OP_SW);
                d.mem_read    = (instr[31:26] == OP_LW);
                d.mem_write   = (instr[31:26] == OP_SW);
                d.reg_write   = (instr[31:26] != OP_SW);
                d.rd          = instr[20:16];
                d.imm         = {{16{instr[15]}}, instr[15:0]};
            end
            OP_ANDI, OP_ORI: begin
                d.alu_op      = (instr[31:26] == OP_ANDI) ? ALU_AND : ALU_OR;
                d.alu_src_imm = 1'b1;
                d.uses_rs     = 1'b1;
                d.reg_write   = 1'b1;
                d.rd          = instr[20:16];
                d.imm         = {16'd0, instr[15:0]};
            end
            OP_LUI: begin
                d.alu_op      = ALU_LUI;
                d.alu_src_imm = 1'b1;
                d.reg_write   = 1'b1;
                d.rd          = instr[20:16];
                d.imm         = {instr[15:0], 16'd0};
            end
            default: d.illegal = 1'b1;
        endcase
        // Unsupported encodings issue as a pure NOP with only the flag set.
        if (d.illegal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile : 2 async read / 1 sync write register file, r0 hard-wired to zero.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [REG_AW-1:0] i_rt_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [2**REG_AW];
    logic              w_fwd_rs;
    logic              w_fwd_rt;

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (WB_BYPASS) begin : g_bypass
            assign w_fwd_rs = i_we && (i_waddr == i_rs_addr);
            assign w_fwd_rt = i_we && (i_waddr == i_rt_addr);
        end else begin : g_no_bypass
            assign w_fwd_rs = 1'b0;
            assign w_fwd_rt = 1'b0;
        end
    endgenerate

    // The r0 check comes first so a forwarded r0 write can never leak through.
    assign o_rs_data = (i_rs_addr == '0) ? '0 : (w_fwd_rs ? i_wdata : r_mem[i_rs_addr]);
    assign o_rt_data = (i_rt_addr == '0) ? '0 : (w_fwd_rt ? i_wdata : r_mem[i_rt_addr]);

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : holds one fetched word, decodes it, resolves jumps/branches and
//            issues a registered bundle to EX. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_stage
    import ace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_next,
    input  logic              hit,
    output logic              pc_we,
    output logic              is_jump,
    output logic [31:0]       jump_addr,
    output logic              is_branch,
    output logic [31:0]       branch_addr,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic [REG_AW-1:0] ex_load_rd,
    input  logic              ex_load_vld,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm,
    output logic [REG_AW-1:0] rd_addr,
    output logic [3:0]        alu_op,
    output logic              alu_src_imm,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic [31:0]       pc_plus4,
    output logic              illegal
);

    id_state_t         r_state;
    logic [31:0]       r_instr;
    logic [31:0]       r_pc_next;

    dec_t              w_dec;
    logic [REG_AW-1:0] w_rs_addr;
    logic [REG_AW-1:0] w_rt_addr;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_hazard;
    logic              w_issue;
    logic              w_taken;
    logic [31:0]       w_br_target;
    logic [31:0]       w_j_target;

    assign w_dec     = decode(r_instr);
    assign w_rs_addr = REG_AW'(r_instr[25:21]);
    assign w_rt_addr = REG_AW'(r_instr[20:16]);

    regfile #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk       (clk),
        .i_rs_addr (w_rs_addr),
        .i_rt_addr (w_rt_addr),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    // Only registers the instruction actually reads can collide with an in-flight load.
    assign w_hazard = ex_load_vld && (ex_load_rd != '0) &&
                      ((w_dec.uses_rs && (ex_load_rd == w_rs_addr)) ||
                       (w_dec.uses_rt && (ex_load_rd == w_rt_addr)));

    assign w_issue     = (r_state == ST_HELD) && !flush && ex_ready && !w_hazard;
    assign w_br_target = r_pc_next + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_j_target  = w_dec.jump_reg ? 32'(w_rs_data)
                                        : {r_pc_next[31:28], r_instr[25:0], 2'b00};
    assign w_taken     = (w_dec.beq && (w_rs_data == w_rt_data)) ||
                         (w_dec.bne && (w_rs_data != w_rt_data));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_instr     <= '0;
            r_pc_next   <= '0;
            id_valid    <= 1'b0;
            pc_we       <= 1'b0;
            is_jump     <= 1'b0;
            is_branch   <= 1'b0;
            jump_addr   <= '0;
            branch_addr <= '0;
            rs_data     <= '0;
            rt_data     <= '0;
            imm         <= '0;
            rd_addr     <= '0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            reg_write   <= 1'b0;
            pc_plus4    <= '0;
            illegal     <= 1'b0;
        end else begin
            id_valid  <= 1'b0;
            pc_we     <= 1'b0;
            is_jump   <= 1'b0;
            is_branch <= 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (hit && !flush) begin
                        r_instr   <= instruction;
                        r_pc_next <= pc_next;
                        r_state   <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (flush) begin
                        r_state <= ST_EMPTY;
                    end else if (w_issue) begin
                        id_valid    <= 1'b1;
                        pc_we       <= 1'b1;
                        is_jump     <= w_dec.jump;
                        is_branch   <= w_taken;
                        jump_addr   <= w_j_target;
                        branch_addr <= w_br_target;
                        rs_data     <= w_rs_data;
                        rt_data     <= w_rt_data;
                        imm         <= DATA_W'(w_dec.imm);
                        rd_addr     <= REG_AW'(w_dec.rd);
                        alu_op      <= w_dec.alu_op;
                        alu_src_imm <= w_dec.alu_src_imm;
                        mem_read    <= w_dec.mem_read;
                        mem_write   <= w_dec.mem_write;
                        reg_write   <= w_dec.reg_write;
                        pc_plus4    <= r_pc_next;
                        illegal     <= w_dec.illegal;
                        r_state     <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Fetch cannot present a new word until it has seen pc_we.
    a_no_hit_in_held: assert property (@(posedge clk) disable iff (!reset)
        !(hit && (r_state == ST_HELD)));

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : directed self-checking bench for id_stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc_next;
    logic        hit;
    logic        pc_we;
    logic        is_jump;
    logic [31:0] jump_addr;
    logic        is_branch;
    logic [31:0] branch_addr;
    logic        flush;
    logic        ex_ready;
    logic [4:0]  ex_load_rd;
    logic        ex_load_vld;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [31:0] pc_plus4;
    logic        illegal;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .REG_AW(5), .WB_BYPASS(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .pc_next     (pc_next),
        .hit         (hit),
        .pc_we       (pc_we),
        .is_jump     (is_jump),
        .jump_addr   (jump_addr),
        .is_branch   (is_branch),
        .branch_addr (branch_addr),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_load_rd  (ex_load_rd),
        .ex_load_vld (ex_load_vld),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .id_valid    (id_valid),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm         (imm),
        .rd_addr     (rd_addr),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .pc_plus4    (pc_plus4),
        .illegal     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called on a negedge; returns on the next negedge with the word captured.
    task automatic hit_word(input logic [31:0] w, input logic [31:0] pc);
        instruction = w;
        pc_next     = pc;
        hit         = 1'b1;
        @(negedge clk);
        hit         = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(negedge clk);
        wb_we   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, ".pc_we"},    32'(pc_we),    32'd0);
    endtask

    initial begin
        reset = 1'b0; instruction = '0; pc_next = '0; hit = 1'b0; flush = 1'b0;
        ex_ready = 1'b1; ex_load_rd = '0; ex_load_vld = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) step();
        chk_idle("rst");
        chk("rst.imm",       imm,       32'd0);
        chk("rst.jump_addr", jump_addr, 32'd0);
        chk("rst.pc_plus4",  pc_plus4,  32'd0);
        reset = 1'b1;
        step();

        // addi r9,r0,5
        hit_word(32'h2009_0005, 32'h0000_0004);
        step();
        chk("addi.id_valid", 32'(id_valid),  32'd1);
        chk("addi.pc_we",    32'(pc_we),     32'd1);
        chk("addi.imm",      imm,            32'd5);
        chk("addi.rd",       32'(rd_addr),   32'd9);
        chk("addi.regwr",    32'(reg_write), 32'd1);
        chk("addi.srcimm",   32'(alu_src_imm), 32'd1);
        chk("addi.pc4",      pc_plus4,       32'h0000_0004);
        step();
        chk_idle("addi.pulse");

        // addi r2,r0,-1 : sign extension
        hit_word(32'h2002_FFFF, 32'h0000_0008);
        step();
        chk("addi_neg.imm", imm, 32'hFFFF_FFFF);

        // branches with r1=r2=7
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        wb_write(5'd5, 32'h20);
        hit_word(32'h1022_0003, 32'h0000_0104);
        step();
        chk("beq.taken",   32'(is_branch), 32'd1);
        chk("beq.addr",    branch_addr,    32'h0000_0110);
        chk("beq.pc_we",   32'(pc_we),     32'd1);
        chk("beq.is_jump", 32'(is_jump),   32'd0);
        chk("beq.regwr",   32'(reg_write), 32'd0);
        hit_word(32'h1422_0003, 32'h0000_0104);
        step();
        chk("bne.taken", 32'(is_branch), 32'd0);
        chk("bne.pc_we", 32'(pc_we),     32'd1);
        hit_word(32'h1022_FFFE, 32'h0000_0104);
        step();
        chk("beq_back.addr", branch_addr, 32'h0000_00FC);
        hit_word(32'h1420_FFFC, 32'h0000_0004);
        step();
        chk("bne_wrap.taken", 32'(is_branch), 32'd1);
        chk("bne_wrap.addr",  branch_addr,    32'hFFFF_FFF4);

        // jumps
        hit_word(32'h0800_0040, 32'hA000_0004);
        step();
        chk("j.is_jump", 32'(is_jump),   32'd1);
        chk("j.addr",    jump_addr,      32'hA000_0100);
        chk("j.regwr",   32'(reg_write), 32'd0);
        hit_word(32'h0C00_0040, 32'hA000_0004);
        step();
        chk("jal.addr",  jump_addr,      32'hA000_0100);
        chk("jal.rd",    32'(rd_addr),   32'd31);
        chk("jal.regwr", 32'(reg_write), 32'd1);
        chk("jal.link",  pc_plus4,       32'hA000_0004);
        hit_word(32'h0020_0008, 32'h0000_0200);
        step();
        chk("jr.is_jump", 32'(is_jump), 32'd1);
        chk("jr.addr",    jump_addr,    32'd7);

        // load-use hazard on ADD r4,r3,r5; r3 rewritten during the stall
        ex_load_vld = 1'b1;
        ex_load_rd  = 5'd3;
        hit_word(32'h0065_2020, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("haz.stall");
        end
        wb_write(5'd3, 32'h11);
        chk_idle("haz.stall_wb");
        ex_load_vld = 1'b0;
        step();
        chk("haz.id_valid", 32'(id_valid), 32'd1);
        chk("haz.rs",       rs_data,       32'h11);
        chk("haz.rt",       rt_data,       32'h20);
        chk("haz.rd",       32'(rd_addr),  32'd4);
        chk("haz.alu",      32'(alu_op),   32'd0);

        // lui r6 does not read r6: no stall from a load to r6
        ex_load_vld = 1'b1;
        ex_load_rd  = 5'd6;
        hit_word(32'h3C06_1234, 32'h0000_0304);
        step();
        chk("lui.id_valid", 32'(id_valid), 32'd1);
        chk("lui.imm",      imm,           32'h1234_0000);
        ex_load_vld = 1'b0;

        // ex_ready low for three cycles: exactly one issue afterwards
        ex_ready = 1'b0;
        hit_word(32'h3407_8001, 32'h0000_0400);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("bp.stall");
        end
        ex_ready = 1'b1;
        step();
        chk("bp.id_valid", 32'(id_valid), 32'd1);
        chk("bp.imm",      imm,           32'h0000_8001);
        step();
        chk_idle("bp.once");

        // flush in HELD drops the word
        ex_ready = 1'b0;
        hit_word(32'h2009_0063, 32'h0000_0500);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ex_ready = 1'b1;
        step();
        chk_idle("flush.a");
        step();
        chk_idle("flush.b");
        hit_word(32'h2009_0007, 32'h0000_0504);
        step();
        chk("flush.next_valid", 32'(id_valid), 32'd1);
        chk("flush.next_imm",   imm,           32'd7);

        // flush in EMPTY drops a coincident hit
        flush = 1'b1;
        hit_word(32'h2009_0008, 32'h0000_0508);
        flush = 1'b0;
        step();
        chk_idle("flush_empty.a");
        step();
        chk_idle("flush_empty.b");

        // same-cycle WB bypass: OR r1,r8,r0
        instruction = 32'h0100_0825;
        pc_next     = 32'h0000_0600;
        hit         = 1'b1;
        step();
        hit     = 1'b0;
        wb_we   = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'h0000_DEAD;
        step();
        wb_we   = 1'b0;
        chk("byp.id_valid", 32'(id_valid), 32'd1);
        chk("byp.rs",       rs_data,       32'h0000_DEAD);
        chk("byp.rt",       rt_data,       32'd0);

        // r0 writes ignored, both stored and forwarded
        wb_write(5'd0, 32'h1234);
        hit_word(32'h0000_0825, 32'h0000_0604);
        step();
        chk("r0.rs", rs_data, 32'd0);
        instruction = 32'h0000_0825;
        hit         = 1'b1;
        step();
        hit     = 1'b0;
        wb_we   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hBEEF;
        step();
        wb_we   = 1'b0;
        chk("r0byp.rs", rs_data, 32'd0);
        chk("r0byp.rt", rt_data, 32'd0);

        // lw r10,4(r1)
        hit_word(32'h8C2A_0004, 32'h0000_0700);
        step();
        chk("lw.memrd", 32'(mem_read),  32'd1);
        chk("lw.rd",    32'(rd_addr),   32'd10);
        chk("lw.rs",    rs_data,        32'd7);

        // illegal opcode issues as NOP
        hit_word(32'hFC00_0000, 32'h0000_0704);
        step();
        chk("ill.flag",  32'(illegal),   32'd1);
        chk("ill.valid", 32'(id_valid),  32'd1);
        chk("ill.regwr", 32'(reg_write), 32'd0);
        chk("ill.memrd", 32'(mem_read),  32'd0);

        // reset while stalled
        ex_ready = 1'b0;
        hit_word(32'h2009_0009, 32'h0000_0800);
        step();
        #1 reset = 1'b0;
        #1;
        chk_idle("rst_stall.now");
        chk("rst_stall.illegal", 32'(illegal), 32'd0);
        step();
        reset    = 1'b1;
        ex_ready = 1'b1;
        step();
        chk_idle("rst_stall.a");
        step();
        chk_idle("rst_stall.b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
